// File: rtl/seq0110_pkg.sv
// Shared types and helpers for the word-level 0110 sequence detector.
// The control FSM and the bit-serial core both import this package.
package seq0110_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } ctrl_state_t;

  // Core states name the longest matched prefix of the pattern: none, 0, 01, 011.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } core_state_t;

  localparam logic [3:0] PATTERN = 4'b0110;

  function automatic core_state_t core_next(input core_state_t s, input logic b);
    core_state_t n;
    n = S0;
    // A 0 always restarts as the leading 0 of a new candidate match.
    if (b == PATTERN[3]) begin
      n = S1;
    end else begin
      case (s)
        S1:      n = (b == PATTERN[2]) ? S2 : S0;
        S2:      n = (b == PATTERN[1]) ? S3 : S0;
        default: n = S0;
      endcase
    end
    return n;
  endfunction

  function automatic logic core_hit(input core_state_t s, input logic b);
    return (s == S3) && (b == PATTERN[0]);
  endfunction

endpackage

// File: rtl/seq0110_stream_ctrl_if.sv
// Word handshake bundle between a parallel producer/consumer and the controller.
// master = producer/consumer side, slave = the controller.
interface seq0110_stream_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_hits;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_hits
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_hits
  );
endinterface

// File: rtl/seq0110_core.sv
// Bit-serial Mealy detector for overlapping 0110. Advances only when en is high;
// clr returns it to S0 on the next edge.
module seq0110_core
  import seq0110_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic hit
);

  core_state_t state_reg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state_reg <= S0;
    end else if (en) begin
      state_reg <= core_next(state_reg, din);
    end
  end

  // Mealy output: valid on the same edge that consumes din.
  assign hit = en & core_hit(state_reg, din);

endmodule

// File: rtl/seq0110_stream_ctrl.sv
// Word-level controller: accepts a word, shifts it MSB-first through the 0110
// core, reports a per-bit hit mask and keeps a saturating match count.
module seq0110_stream_ctrl
  import seq0110_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  seq0110_stream_ctrl_if.slave bus,
  input  logic                 flush,
  input  logic                 count_clr,
  output logic [CNT_W-1:0]     match_count,
  output logic                 busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctrl_state_t      state_reg;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] hits_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             out_valid_reg;
  logic             busy_reg;
  logic [CNT_W-1:0] count_reg;

  logic             accept;
  logic             shifting;
  logic             core_bit;
  logic             core_clr;
  logic             core_hit_w;
  logic [WIDTH-1:0] hit_wr_en;

  assign bus.in_ready  = (state_reg == IDLE) & ~reset;
  assign accept        = bus.in_valid & bus.in_ready;
  assign shifting      = (state_reg == SHIFT);
  assign core_bit      = data_reg[idx_reg];
  // Flush coinciding with accept still lands before the first bit is consumed.
  assign core_clr      = (state_reg == IDLE) & flush;

  seq0110_core u_core (
    .clk   (clk),
    .reset (reset),
    .en    (shifting),
    .clr   (core_clr),
    .din   (core_bit),
    .hit   (core_hit_w)
  );

  // One-hot write enable selecting the hit-mask bit for the bit being consumed.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_hit_sel
    assign hit_wr_en[gi] = shifting && (idx_reg == IDX_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      data_reg      <= '0;
      hits_reg      <= '0;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            data_reg  <= bus.in_data;
            idx_reg   <= IDX_LAST;
            hits_reg  <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          hits_reg <= hits_reg | (hit_wr_en & {WIDTH{core_hit_w}});
          if (idx_reg == '0) begin
            out_valid_reg <= 1'b1;
            state_reg     <= REPORT;
          end else begin
            idx_reg <= idx_reg - 1'b1;
          end
        end
        REPORT: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || count_clr) begin
      count_reg <= '0;
    end else if (core_hit_w && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_hits  = hits_reg;
  assign match_count   = count_reg;
  assign busy          = busy_reg;

endmodule
